// File: rtl/mac_pkg.sv
// Shared definitions for the FP32 Horner polynomial evaluator: field constants, FSM states and
// truncating single-precision multiply/add helpers.
package mac_pkg;

  localparam int unsigned FpWidth   = 32;
  localparam int unsigned ExpWidth  = 8;
  localparam int unsigned FracWidth = 23;
  localparam logic [7:0]  ExpMax    = 8'hFF;
  localparam logic [31:0] FpQnan    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    StIdle,
    StLoadSig,
    StLoadCoef,
    StEval,
    StDone
  } mac_state_e;

  // Any NaN terminates a load stream.
  function automatic logic is_sentinel(input logic [31:0] w);
    return (w[30:23] == ExpMax) && (w[22:0] != '0);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              sgn;
    logic [47:0]       prod;
    logic [22:0]       frac;
    logic signed [9:0] e;
    sgn  = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) begin
      frac = prod[46:24];
      e    = e + 10'sd1;
    end else begin
      frac = prod[45:23];
    end
    if ((a[30:23] == ExpMax) || (b[30:23] == ExpMax)) begin
      if ((a[30:23] == 8'h00) || (b[30:23] == 8'h00)) return FpQnan;
      return {sgn, ExpMax, 23'd0};
    end
    if ((a[30:23] == 8'h00) || (b[30:23] == 8'h00)) return {sgn, 31'd0};
    if (e >= 10'sd255) return {sgn, ExpMax, 23'd0};
    if (e <= 10'sd0) return {sgn, 31'd0};
    return {sgn, e[7:0], frac};
  endfunction

  // Guard/round/sticky bits keep the truncated result exact for round-toward-zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       big;
    logic [31:0]       sml;
    logic [7:0]        diff;
    logic [4:0]        sh;
    logic [26:0]       mb;
    logic [26:0]       ms;
    logic [53:0]       wide;
    logic [27:0]       sum;
    logic [26:0]       norm;
    logic [4:0]        lz;
    logic signed [9:0] e;
    if ((a[30:23] == 8'h00) && (b[30:23] == 8'h00)) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:23] == ExpMax) return ((b[30:23] == ExpMax) && (a[31] != b[31])) ? FpQnan : a;
    if (b[30:23] == ExpMax) return b;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    diff = big[30:23] - sml[30:23];
    sh   = (diff > 8'd31) ? 5'd31 : diff[4:0];
    mb   = {1'b1, big[22:0], 3'b000};
    wide = {1'b1, sml[22:0], 3'b000, 27'd0} >> sh;
    ms   = wide[53:27] | {26'd0, |wide[26:0]};
    e    = $signed({2'b00, big[30:23]});
    if (big[31] == sml[31]) begin
      sum = {1'b0, mb} + {1'b0, ms};
      if (sum[27]) begin
        norm = sum[27:1] | {26'd0, sum[0]};
        e    = e + 10'sd1;
      end else begin
        norm = sum[26:0];
      end
    end else begin
      sum = {1'b0, mb} - {1'b0, ms};
      if (sum == '0) return 32'h0;
      lz = '0;
      for (int i = 0; i < 27; i++) begin
        if (sum[i]) lz = 5'(26 - i);
      end
      norm = sum[26:0] << lz;
      e    = e - $signed({5'd0, lz});
    end
    if (e >= 10'sd255) return {big[31], ExpMax, 23'd0};
    if (e <= 10'sd0) return {big[31], 31'd0};
    return {big[31], e[7:0], norm[25:3]};
  endfunction

endpackage

// File: rtl/mac_fifo.sv
// Single-clock store with count/full/empty and a read pointer that can either consume the head,
// step through entries without consuming them, or rewind to entry 0.
module mac_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_LINES = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  input  logic                  step_i,
  input  logic                  rewind_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_LINES-1:0] rd_idx_o,
  output logic [ADDR_LINES:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned Depth = 2 ** ADDR_LINES;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_LINES-1:0] wr_ptr_q;
  logic [ADDR_LINES-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_LINES:0]   count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign full_o   = (count_q == (ADDR_LINES + 1)'(Depth));
  assign empty_o  = (count_q == '0);
  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  assign rdata_o  = mem_q[rd_ptr_q];
  assign rd_idx_o = rd_ptr_q;
  assign count_o  = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rewind_i) begin
      rd_ptr_d = '0;
    end else if (do_pop || step_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  // Storage carries no reset; only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mac.sv
// FP32 polynomial evaluator: loads NaN-terminated x and coefficient streams, then evaluates
// P(x) by Horner's rule, one multiply-add per cycle, for every buffered x.
module mac
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_LINES = 5
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] signal_fifo,
  input  logic [DATA_WIDTH-1:0] coeff_fifo,
  output logic                  full_mul,
  output logic                  empty_mul,
  output logic                  full_adder,
  output logic                  empty_adder,
  output logic [DATA_WIDTH-1:0] result
);

  mac_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                  sig_push, sig_pop;
  logic                  coef_push, coef_step, coef_rewind;
  logic [DATA_WIDTH-1:0] sig_rdata, coef_rdata;
  logic [ADDR_LINES-1:0] coef_idx;
  logic [ADDR_LINES:0]   sig_count, coef_count;
  logic                  coef_first, coef_last;
  logic [DATA_WIDTH-1:0] horner;

  mac_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_LINES(ADDR_LINES)
  ) u_sig_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rstn_i),
    .push_i  (sig_push),
    .wdata_i (signal_fifo),
    .pop_i   (sig_pop),
    .step_i  (1'b0),
    .rewind_i(1'b0),
    .rdata_o (sig_rdata),
    .rd_idx_o(),
    .count_o (sig_count),
    .full_o  (full_mul),
    .empty_o (empty_mul)
  );

  mac_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_LINES(ADDR_LINES)
  ) u_coef_store (
    .clk_i   (clk_i),
    .rst_ni  (rstn_i),
    .push_i  (coef_push),
    .wdata_i (coeff_fifo),
    .pop_i   (1'b0),
    .step_i  (coef_step),
    .rewind_i(coef_rewind),
    .rdata_o (coef_rdata),
    .rd_idx_o(coef_idx),
    .count_o (coef_count),
    .full_o  (full_adder),
    .empty_o (empty_adder)
  );

  assign coef_first = (coef_idx == '0);
  assign coef_last  = ({1'b0, coef_idx} == (coef_count - 1'b1));
  assign horner     = coef_first ? coef_rdata : fp_add(fp_mul(acc_q, sig_rdata), coef_rdata);
  assign result     = result_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    result_d    = result_q;
    sig_push    = 1'b0;
    sig_pop     = 1'b0;
    coef_push   = 1'b0;
    coef_step   = 1'b0;
    coef_rewind = 1'b0;
    unique case (state_q)
      StIdle: state_d = StLoadSig;
      StLoadSig: begin
        if (is_sentinel(signal_fifo)) state_d = StLoadCoef;
        else sig_push = 1'b1;
      end
      StLoadCoef: begin
        if (is_sentinel(coeff_fifo)) begin
          state_d = (empty_mul || empty_adder) ? StDone : StEval;
        end else begin
          coef_push = 1'b1;
        end
      end
      StEval: begin
        acc_d = horner;
        if (coef_last) begin
          // Finish this x: publish, consume it, and restart the coefficient walk.
          result_d    = horner;
          sig_pop     = 1'b1;
          coef_rewind = 1'b1;
          if (sig_count == (ADDR_LINES + 1)'(1)) state_d = StDone;
        end else begin
          coef_step = 1'b1;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mac.sv
// Directed bench for mac: reset values, quadratic, exp series, fill, empty coefficients, mid-run
// reset.
module tb_mac;

  localparam logic [31:0] F0   = 32'h0000_0000;
  localparam logic [31:0] F1   = 32'h3F80_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;
  localparam logic [31:0] F3   = 32'h4040_0000;
  localparam logic [31:0] F11  = 32'h4130_0000;
  localparam logic [31:0] FNAN = 32'h7FC0_0000;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] signal_fifo = '0;
  logic [31:0] coeff_fifo = '0;
  logic        full_mul, empty_mul, full_adder, empty_adder;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail = 0;

  mac #(
    .DATA_WIDTH(32),
    .ADDR_LINES(5)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .signal_fifo(signal_fifo),
    .coeff_fifo (coeff_fifo),
    .full_mul   (full_mul),
    .empty_mul  (empty_mul),
    .full_adder (full_adder),
    .empty_adder(empty_adder),
    .result     (result)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] s, input logic [31:0] c);
    signal_fifo = s;
    coeff_fifo  = c;
    tick(1);
  endtask

  // Leaves the DUT just past its IDLE cycle, ready to sample the first x.
  task automatic do_reset();
    rstn_i      = 1'b0;
    signal_fifo = '0;
    coeff_fifo  = '0;
    tick(2);
    rstn_i = 1'b1;
    tick(1);
  endtask

  task automatic quad_load();
    drive(F2, F0);
    drive(F0, F0);
    drive(FNAN, F0);
    drive(F0, F1);
    drive(F0, F2);
    drive(F0, F3);
    drive(F0, FNAN);
  endtask

  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    logic [10:0] e11;
    if (r == 0.0) return 32'h0;
    d   = $realtobits(r);
    e11 = d[62:52] - 11'd896;
    return {d[63], e11[7:0], d[51:29]};
  endfunction

  function automatic real from_f32(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e11;
    if (f[30:23] == 8'h00) return 0.0;
    e11 = {3'b000, f[30:23]} + 11'd896;
    d   = {f[31], e11, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    real xs[30];
    real fact;
    real got_r, exp_r, err;
    logic ok;
    logic [31:0] w;

    // Reset values while held in reset
    rstn_i = 1'b0;
    tick(2);
    check("rst_result", result, F0);
    check("rst_empty_mul", {31'd0, empty_mul}, 32'd1);
    check("rst_empty_adder", {31'd0, empty_adder}, 32'd1);
    check("rst_full_mul", {31'd0, full_mul}, 32'd0);
    check("rst_full_adder", {31'd0, full_adder}, 32'd0);

    // Quadratic 1*x^2 + 2*x + 3 at x = 2, 0
    do_reset();
    quad_load();
    check("quad_empty_mul_loaded", {31'd0, empty_mul}, 32'd0);
    tick(2);
    check("quad_before_first", result, F0);
    tick(1);
    check("quad_x2", result, F11);
    tick(3);
    check("quad_x0", result, F3);
    check("quad_empty_mul_done", {31'd0, empty_mul}, 32'd1);
    check("quad_empty_adder_done", {31'd0, empty_adder}, 32'd0);
    tick(4);
    check("quad_hold", result, F3);

    // exp(x) via 26 Taylor coefficients, 30 samples over [-5, 5]
    do_reset();
    for (int i = 0; i < 30; i++) begin
      w     = to_f32(-5.0 + 10.0 * i / 29.0);
      xs[i] = from_f32(w);
      drive(w, F0);
    end
    drive(FNAN, F0);
    for (int k = 0; k < 26; k++) begin
      fact = 1.0;
      for (int j = 2; j <= 25 - k; j++) fact = fact * j;
      drive(F0, to_f32(1.0 / fact));
    end
    drive(F0, FNAN);
    for (int i = 0; i < 30; i++) begin
      tick(26);
      got_r = from_f32(result);
      exp_r = $exp(xs[i]);
      err   = got_r - exp_r;
      if (err < 0.0) err = -err;
      ok = (err <= 1.0e-3 * exp_r + 1.0e-4);
      if (!ok) $display("exp sample %0d: got %g want %g", i, got_r, exp_r);
      check("exp_sample", {31'd0, ok}, 32'd1);
    end
    check("exp_empty_mul_done", {31'd0, empty_mul}, 32'd1);

    // Fill: 33 x words, the 33rd (3.0) must be dropped; P(x) = 1*x + 0 echoes x
    do_reset();
    for (int i = 0; i < 33; i++) begin
      w = (i == 0) ? F2 : ((i == 32) ? F3 : F1);
      drive(w, F0);
      if (i == 30) check("fill_not_full_31", {31'd0, full_mul}, 32'd0);
      if (i == 31) check("fill_full_32", {31'd0, full_mul}, 32'd1);
    end
    check("fill_full_33", {31'd0, full_mul}, 32'd1);
    check("fill_not_empty", {31'd0, empty_mul}, 32'd0);
    drive(FNAN, F0);
    drive(F0, F1);
    drive(F0, F0);
    drive(F0, FNAN);
    check("fill_adder_not_empty", {31'd0, empty_adder}, 32'd0);
    check("fill_adder_not_full", {31'd0, full_adder}, 32'd0);
    tick(2);
    check("fill_first_x", result, F2);
    tick(2);
    check("fill_second_x", result, F1);
    tick(60);
    check("fill_last_x", result, F1);
    check("fill_drained", {31'd0, empty_mul}, 32'd1);

    // Empty coefficient list goes straight to DONE
    do_reset();
    drive(F2, F0);
    drive(FNAN, F0);
    drive(F0, FNAN);
    drive(F1, F1);
    tick(5);
    check("nocoef_result", result, F0);
    check("nocoef_empty_adder", {31'd0, empty_adder}, 32'd1);
    check("nocoef_empty_mul", {31'd0, empty_mul}, 32'd0);

    // Asynchronous reset in the middle of evaluation, then a clean rerun
    do_reset();
    quad_load();
    tick(3);
    check("midrst_first", result, F11);
    tick(1);
    #2 rstn_i = 1'b0;
    #1;
    check("midrst_result", result, F0);
    check("midrst_empty_mul", {31'd0, empty_mul}, 32'd1);
    check("midrst_empty_adder", {31'd0, empty_adder}, 32'd1);
    check("midrst_full_adder", {31'd0, full_adder}, 32'd0);
    do_reset();
    quad_load();
    tick(3);
    check("rerun_x2", result, F11);
    tick(3);
    check("rerun_x0", result, F3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
